// File: rtl/alu_scan_pkg.sv
// Shared types for the ALU scan test sequencer.
// Holds the sequencer state encoding and the ALU op code values.
package alu_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register, shifting towards the MSB.
// A load takes priority over a shift in the same cycle.
module scan_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {r_q[WIDTH-2:0], i_ser_in};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/alu_scan_ctrl.sv
// Scan test sequencer: shift stimulus in, capture one ALU cycle,
// shift the response out and compare it against the expected value.
module alu_scan_ctrl
    import alu_scan_pkg::*;
#(
    parameter int CHAIN_LEN = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [CHAIN_LEN-1:0] i_pattern_in,
    input  logic [CHAIN_LEN-1:0] i_expected,
    input  logic [1:0]           i_op_sel,
    input  logic                 i_scan_out_dut,
    output logic                 o_scan_en,
    output logic                 o_scan_in,
    output logic [1:0]           o_op_code,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [CHAIN_LEN-1:0] o_captured
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_scan_en;
    logic [1:0]           r_op_code;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_cnt_last;
    logic                 w_stim_load;
    logic [CHAIN_LEN-1:0] w_stim_val;
    logic                 w_stim_shift;
    logic                 w_resp_shift;
    logic [CHAIN_LEN-1:0] w_stim;
    logic [CHAIN_LEN-2:0] w_stim_unused;
    logic [CHAIN_LEN-1:0] w_captured;
    logic [CHAIN_LEN-1:0] w_resp_next;

    assign w_accept     = (r_state == S_IDLE) && i_start && !i_abort;
    assign w_abort      = i_abort && (r_state != S_IDLE);
    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_stim_load  = w_accept || w_abort;
    assign w_stim_val   = w_accept ? i_pattern_in : '0;
    assign w_stim_shift = (r_state == S_SHIFT_IN);
    assign w_resp_shift = (r_state == S_SHIFT_OUT) && !i_abort;
    assign w_resp_next  = {w_captured[CHAIN_LEN-2:0], i_scan_out_dut};

    // Stimulus MSB is scan_in; zero fill leaves it low after the shift.
    scan_shift_reg #(
        .WIDTH(CHAIN_LEN)
    ) u_stim (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_stim_load),
        .i_load_val(w_stim_val),
        .i_shift   (w_stim_shift),
        .i_ser_in  (1'b0),
        .o_q       (w_stim)
    );

    scan_shift_reg #(
        .WIDTH(CHAIN_LEN)
    ) u_resp (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (1'b0),
        .i_load_val('0),
        .i_shift   (w_resp_shift),
        .i_ser_in  (i_scan_out_dut),
        .o_q       (w_captured)
    );

    assign w_stim_unused = w_stim[CHAIN_LEN-2:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_expected <= '0;
            r_scan_en  <= 1'b0;
            r_op_code  <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else if (w_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_scan_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_SHIFT_IN;
                        r_cnt      <= '0;
                        r_scan_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_op_code  <= i_op_sel;
                        r_expected <= i_expected;
                    end
                end
                S_SHIFT_IN: begin
                    if (w_cnt_last) begin
                        r_state   <= S_CAPTURE;
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_state   <= S_SHIFT_OUT;
                    r_cnt     <= '0;
                    r_scan_en <= 1'b1;
                end
                S_SHIFT_OUT: begin
                    if (w_cnt_last) begin
                        // Compare against the value completing on this edge.
                        r_state   <= S_DONE;
                        r_cnt     <= '0;
                        r_scan_en <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= (w_resp_next == r_expected);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_scan_en  = r_scan_en;
    assign o_scan_in  = w_stim[CHAIN_LEN-1];
    assign o_op_code  = r_op_code;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_captured = w_captured;

endmodule
